// File: rtl/prog_sched.sv
// Job scheduler: queues program start addresses and launches them one at a time
// on a CPU core, reporting each job's address, run length and timeout status.
module prog_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        push_i,
    input  logic [7:0]  push_addr_i,
    output logic        full_o,
    output logic [2:0]  depth_o,
    output logic        drop_o,
    output logic        core_start_o,
    output logic [7:0]  core_addr_o,
    input  logic        core_done_i,
    output logic        busy_o,
    output logic        job_done_o,
    output logic [7:0]  job_addr_o,
    output logic [15:0] job_cycles_o,
    output logic        timeout_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      depth_q, depth_d;
    logic            full_q, full_d;
    logic            drop_q, drop_d;
    logic            start_q, start_d;
    logic [7:0]      core_addr_q, core_addr_d;
    logic            busy_q, busy_d;
    logic            job_done_q, job_done_d;
    logic [7:0]      job_addr_q, job_addr_d;
    logic [CW-1:0]   job_cycles_q, job_cycles_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_prev_q, done_prev_d;
    logic            by_timeout_q, by_timeout_d;
    logic            push_ok;
    logic            pop;

    // Next-state, queue bookkeeping and output computation
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        depth_d      = depth_q;
        drop_d       = 1'b0;
        start_d      = 1'b0;
        core_addr_d  = core_addr_q;
        job_done_d   = 1'b0;
        job_addr_d   = job_addr_q;
        job_cycles_d = job_cycles_q;
        timeout_d    = 1'b0;
        cnt_d        = cnt_q;
        done_prev_d  = core_done_i;
        by_timeout_d = by_timeout_q;
        pop          = 1'b0;
        push_ok      = push_i && !full_q;

        case (state_q)
            IDLE: begin
                if (depth_q != 3'd0) begin
                    pop         = 1'b1;
                    core_addr_d = mem_q[rd_ptr_q];
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // Only a fresh rising edge of done counts; a level left over from a prior job is ignored
                if (core_done_i && !done_prev_q) begin
                    by_timeout_d = 1'b0;
                    state_d      = REPORT;
                end else if (cnt_q == TIMEOUT) begin
                    by_timeout_d = 1'b1;
                    state_d      = REPORT;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REPORT: begin
                job_done_d   = 1'b1;
                job_addr_d   = core_addr_q;
                job_cycles_d = cnt_q;
                timeout_d    = by_timeout_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            depth_d = depth_q + 3'd1;
        end else if (!push_ok && pop) begin
            depth_d = depth_q - 3'd1;
        end

        drop_d = push_i && full_q;
        full_d = (depth_d == 3'(DEPTH));
        busy_d = (state_d != IDLE);
    end

    // Control and output registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            depth_q      <= '0;
            full_q       <= 1'b0;
            drop_q       <= 1'b0;
            start_q      <= 1'b0;
            core_addr_q  <= '0;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            job_addr_q   <= '0;
            job_cycles_q <= '0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            done_prev_q  <= 1'b0;
            by_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            depth_q      <= depth_d;
            full_q       <= full_d;
            drop_q       <= drop_d;
            start_q      <= start_d;
            core_addr_q  <= core_addr_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            job_addr_q   <= job_addr_d;
            job_cycles_q <= job_cycles_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            done_prev_q  <= done_prev_d;
            by_timeout_q <= by_timeout_d;
        end
    end

    // Queue storage; contents are only meaningful behind the pointers, so no reset
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_addr_i;
        end
    end

    assign full_o       = full_q;
    assign depth_o      = depth_q;
    assign drop_o       = drop_q;
    assign core_start_o = start_q;
    assign core_addr_o  = core_addr_q;
    assign busy_o       = busy_q;
    assign job_done_o   = job_done_q;
    assign job_addr_o   = job_addr_q;
    assign job_cycles_o = job_cycles_q;
    assign timeout_o    = timeout_q;

endmodule
